// File: rtl/multicycle_control_unit_if.sv
// Instruction/data-memory handshake and datapath strobe bundle for multicycle_control_unit.
// master: datapath/memory side; slave: the control unit.
interface multicycle_control_unit_if #(
  parameter int unsigned INSTR_WIDTH = 32
);
  logic [INSTR_WIDTH-1:0] instr;
  logic                   instr_valid;
  logic                   EQ;
  logic                   mem_ready;
  logic                   PCWrite;
  logic                   IRWrite;
  logic                   RegWrite;
  logic [2:0]             ALUctrl;
  logic                   ALUsrc;
  logic [2:0]             ImmSrc;
  logic                   PCsrc;
  logic                   MemWrite;
  logic                   MemRead;
  logic [1:0]             ResultSrc;
  logic                   mem_timeout;
  logic                   trap;

  modport master (
    output instr, instr_valid, EQ, mem_ready,
    input  PCWrite, IRWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc,
           MemWrite, MemRead, ResultSrc, mem_timeout, trap
  );

  modport slave (
    input  instr, instr_valid, EQ, mem_ready,
    output PCWrite, IRWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc,
           MemWrite, MemRead, ResultSrc, mem_timeout, trap
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC | MEM [-> WB] -> FETCH.
// Data-memory waits are bounded by a TIMEOUT_MAX cycle counter.
// Optional macro TRAP_EN: illegal opcodes and memory timeouts halt the core in TRAP;
// without it, illegal opcodes retire as NOPs and timeouts retire the access.
module multicycle_control_unit #(
  parameter int unsigned INSTR_WIDTH   = 32,
  parameter int unsigned TIMEOUT_WIDTH = 4,
  parameter int unsigned TIMEOUT_MAX   = 15
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_unit_if.slave bus
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t                   state, next_state;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt;
  logic                     cnt_clr, cnt_inc, timeout_set;
  logic                     mem_timeout_q;

  logic       pc_write, ir_write, reg_write, alu_src, pc_src, mem_write, mem_read, trap_c;
  logic [2:0] alu_ctrl, imm_src;
  logic [1:0] result_src;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       unused_instr_bits;

  assign opcode            = bus.instr[6:0];
  assign funct3            = bus.instr[14:12];
  assign funct7b5          = bus.instr[30];
  assign unused_instr_bits = ^{bus.instr[INSTR_WIDTH-1:31], bus.instr[29:15], bus.instr[11:7]};

  // ALU operation for OP-IMM / OP (sub only for R-type funct7[5]).
  function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_op = sub ? 3'b001 : 3'b000;
      3'b110:  alu_op = 3'b011;
      3'b111:  alu_op = 3'b010;
      3'b010:  alu_op = 3'b101;
      default: alu_op = 3'b000;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // Memory-wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt      <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      if (cnt_clr)      wait_cnt <= '0;
      else if (cnt_inc) wait_cnt <= wait_cnt + TIMEOUT_WIDTH'(1);
      if (timeout_set) mem_timeout_q <= 1'b1;
    end
  end

  // Next-state and Moore strobes with instruction decode.
  always_comb begin
    next_state  = state;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    timeout_set = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    alu_ctrl    = 3'b000;
    alu_src     = 1'b0;
    imm_src     = 3'b000;
    pc_src      = 1'b0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    result_src  = 2'b00;
    trap_c      = 1'b0;

    case (state)
      S_FETCH: begin
        if (bus.instr_valid && rst_n) begin
          ir_write   = 1'b1;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_IMM, OP_REG, OP_LUI, OP_BRANCH, OP_JAL: next_state = S_EXEC;
          OP_LOAD, OP_STORE: begin
            next_state = S_MEM;
            cnt_clr    = 1'b1;
          end
`ifdef TRAP_EN
          default: next_state = S_TRAP;
`else
          default: next_state = S_EXEC;
`endif
        endcase
      end

      S_EXEC: begin
        pc_write   = 1'b1;
        next_state = S_FETCH;
        case (opcode)
          OP_IMM: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            alu_ctrl  = alu_op(funct3, 1'b0);
          end
          OP_REG: begin
            reg_write = 1'b1;
            alu_ctrl  = alu_op(funct3, funct7b5);
          end
          OP_LUI: begin
            reg_write  = 1'b1;
            imm_src    = 3'b100;
            result_src = 2'b11;
          end
          OP_BRANCH: begin
            alu_ctrl = 3'b001;
            imm_src  = 3'b010;
            pc_src   = ((funct3 == 3'b000) && bus.EQ) || ((funct3 == 3'b001) && !bus.EQ);
          end
          OP_JAL: begin
            reg_write  = 1'b1;
            imm_src    = 3'b011;
            result_src = 2'b10;
            pc_src     = 1'b1;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        alu_src   = 1'b1;
        imm_src   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
        mem_write = (opcode == OP_STORE);
        mem_read  = (opcode != OP_STORE);
        if (bus.mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_write   = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end else if (wait_cnt == TIMEOUT_WIDTH'(TIMEOUT_MAX)) begin
          timeout_set = 1'b1;
`ifdef TRAP_EN
          next_state  = S_TRAP;
`else
          pc_write    = 1'b1;
          next_state  = S_FETCH;
`endif
        end else begin
          cnt_inc = 1'b1;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end

      S_TRAP: begin
`ifdef TRAP_EN
        trap_c = 1'b1;
`endif
        next_state = S_TRAP;
      end

      default: next_state = S_FETCH;
    endcase
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IRWrite     = ir_write;
  assign bus.RegWrite    = reg_write;
  assign bus.ALUctrl     = alu_ctrl;
  assign bus.ALUsrc      = alu_src;
  assign bus.ImmSrc      = imm_src;
  assign bus.PCsrc       = pc_src;
  assign bus.MemWrite    = mem_write;
  assign bus.MemRead     = mem_read;
  assign bus.ResultSrc   = result_src;
  assign bus.mem_timeout = mem_timeout_q;
  assign bus.trap        = trap_c;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (TIMEOUT_MAX = 15).
// Expectations follow the TRAP_EN macro when the bench is built with it.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  localparam logic [14:0] NONE = 15'd0;

  multicycle_control_unit_if #(.INSTR_WIDTH(32)) bus ();

  multicycle_control_unit #(
    .INSTR_WIDTH  (32),
    .TIMEOUT_WIDTH(4),
    .TIMEOUT_MAX  (15)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {PCWrite, IRWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc, MemWrite, MemRead, ResultSrc}
  function automatic logic [14:0] sv(input logic pcw, input logic irw, input logic rw,
                                     input logic [2:0] alu, input logic alus, input logic [2:0] imm,
                                     input logic pcs, input logic mw, input logic mr,
                                     input logic [1:0] rs);
    sv = {pcw, irw, rw, alu, alus, imm, pcs, mw, mr, rs};
  endfunction

  function automatic logic [14:0] obs();
    obs = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.ALUctrl, bus.ALUsrc, bus.ImmSrc,
           bus.PCsrc, bus.MemWrite, bus.MemRead, bus.ResultSrc};
  endfunction

  task automatic check_st(input string tag, input logic [14:0] exp);
    check(tag, 32'(obs()), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH (with IRWrite) then DECODE; leaves the DUT in the state after DECODE.
  task automatic fetch_decode(input string tag, input logic [31:0] ins);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    #1;
    check_st({tag, "_fetch"}, sv(0,1,0,3'b000,0,3'b000,0,0,0,2'b00));
    tick();
    bus.instr_valid = 1'b0;
    #1;
    check_st({tag, "_decode"}, NONE);
    tick();
  endtask

  // Single-cycle EXEC instruction, returning to FETCH.
  task automatic run_exec(input string tag, input logic [31:0] ins, input logic eq,
                          input logic [14:0] exp);
    bus.EQ = eq;
    fetch_decode(tag, ins);
    #1;
    check_st({tag, "_exec"}, exp);
    tick();
    check_st({tag, "_back_fetch"}, NONE);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_st("rst_outs", NONE);
    check("rst_timeout", 32'(bus.mem_timeout), 32'd0);
    check("rst_trap", 32'(bus.trap), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  logic exp_trap;

  initial begin
`ifdef TRAP_EN
    exp_trap = 1'b1;
`else
    exp_trap = 1'b0;
`endif
    rst_n           = 1'b1;
    bus.instr       = 32'h0;
    bus.instr_valid = 1'b0;
    bus.EQ          = 1'b0;
    bus.mem_ready   = 1'b0;
    #2;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b1;
    #11;
    check_st("reset_outs", NONE);
    check("reset_timeout", 32'(bus.mem_timeout), 32'd0);
    check("reset_trap", 32'(bus.trap), 32'd0);
    bus.instr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;

    // ALU / lui / branch / jal
    run_exec("addi", 32'h00500093, 1'b0, sv(1,0,1,3'b000,1,3'b000,0,0,0,2'b00));
    run_exec("ori",  32'h0ff0e093, 1'b0, sv(1,0,1,3'b011,1,3'b000,0,0,0,2'b00));
    run_exec("sub",  32'h40208133, 1'b0, sv(1,0,1,3'b001,0,3'b000,0,0,0,2'b00));
    run_exec("slt",  32'h0020a1b3, 1'b0, sv(1,0,1,3'b101,0,3'b000,0,0,0,2'b00));
    run_exec("bne_ne", 32'h00209463, 1'b0, sv(1,0,0,3'b001,0,3'b010,1,0,0,2'b00));
    run_exec("bne_eq", 32'h00209463, 1'b1, sv(1,0,0,3'b001,0,3'b010,0,0,0,2'b00));
    run_exec("beq_eq", 32'h00208463, 1'b1, sv(1,0,0,3'b001,0,3'b010,1,0,0,2'b00));
    run_exec("lui",  32'h123450b7, 1'b0, sv(1,0,1,3'b000,0,3'b100,0,0,0,2'b11));
    run_exec("jal",  32'h008000ef, 1'b0, sv(1,0,1,3'b000,0,3'b011,1,0,0,2'b10));
    bus.EQ = 1'b0;

    // lw with three wait cycles: 7 cycles total
    fetch_decode("lw", 32'h00002183);
    for (int i = 0; i < 3; i++) begin
      check_st("lw_wait", sv(0,0,0,3'b000,1,3'b000,0,0,1,2'b00));
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    check_st("lw_ready", sv(0,0,0,3'b000,1,3'b000,0,0,1,2'b00));
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check_st("lw_wb", sv(1,0,1,3'b000,0,3'b000,0,0,0,2'b01));
    tick();
    check_st("lw_back_fetch", NONE);
    check("lw_no_timeout", 32'(bus.mem_timeout), 32'd0);

    // sw with mem_ready held low: timeout on the 16th MEM cycle
    fetch_decode("sw_to", 32'h00302223);
    for (int i = 0; i < 15; i++) begin
      check_st("sw_to_wait", sv(0,0,0,3'b000,1,3'b001,0,1,0,2'b00));
      check("sw_to_flag_early", 32'(bus.mem_timeout), 32'd0);
      tick();
    end
    check_st("sw_to_last", sv(!exp_trap,0,0,3'b000,1,3'b001,0,1,0,2'b00));
    tick();
    check_st("sw_to_after", NONE);
    check("sw_to_flag", 32'(bus.mem_timeout), 32'd1);
    check("sw_to_trap", 32'(bus.trap), 32'(exp_trap));
    tick();
    check("sw_to_flag_sticky", 32'(bus.mem_timeout), 32'd1);
    if (exp_trap) apply_reset();

    // sw with immediate mem_ready: PCWrite in MEM, 3 cycles
    fetch_decode("sw", 32'h00302223);
    bus.mem_ready = 1'b1;
    #1;
    check_st("sw_mem", sv(1,0,0,3'b000,1,3'b001,0,1,0,2'b00));
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check_st("sw_back_fetch", NONE);
    check("sw_flag", 32'(bus.mem_timeout), 32'(!exp_trap));

    // reset in the middle of a lw wait
    fetch_decode("lw_rst", 32'h00002183);
    tick();
    tick();
    check_st("lw_rst_wait", sv(0,0,0,3'b000,1,3'b000,0,0,1,2'b00));
    apply_reset();
    check("lw_rst_flag", 32'(bus.mem_timeout), 32'd0);
    run_exec("post_rst_addi", 32'h00500093, 1'b0, sv(1,0,1,3'b000,1,3'b000,0,0,0,2'b00));

    // illegal opcode
    fetch_decode("ill", 32'hffffffff);
    check_st("ill_exec", exp_trap ? NONE : sv(1,0,0,3'b000,0,3'b000,0,0,0,2'b00));
    check("ill_trap", 32'(bus.trap), 32'(exp_trap));
    tick();
    bus.instr_valid = 1'b1;
    #1;
    check_st("ill_after", exp_trap ? NONE : sv(0,1,0,3'b000,0,3'b000,0,0,0,2'b00));
    check("ill_trap_hold", 32'(bus.trap), 32'(exp_trap));
    bus.instr_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle control FSM for the RV32I datapath, replacing the single-cycle combinational decoder. Sequences each instruction through fetch, decode, execute, memory and writeback. Handshakes with instruction and data memory, and bounds data-memory waits with a timeout counter. Drives the same datapath strobe names plus PC/IR write enables and status flags.

## Interface
Parameters:
- INSTR_WIDTH, 32: instruction width; opcode [6:0], funct3 [14:12], funct7[5] at bit 30.
- TIMEOUT_WIDTH, 4: width of the memory-wait counter.
- TIMEOUT_MAX, 15: wait cycles allowed before timeout. Must satisfy 1 ≤ TIMEOUT_MAX ≤ 2^TIMEOUT_WIDTH−1.

Ports:
- clk  in  1  — single clock, rising edge.
- rst_n  in  1  — asynchronous, active-low reset.
- instr  in  INSTR_WIDTH  — current instruction register contents; stable from the cycle after IRWrite.
- instr_valid  in  1  — instruction memory data valid.
- EQ  in  1  — ALU equality flag.
- mem_ready  in  1  — data memory completed the access.
- PCWrite  out  1  — PC register update enable.
- IRWrite  out  1  — instruction register load enable.
- RegWrite  out  1  — register file write enable.
- ALUctrl  out  3  — ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ALUsrc  out  1  — ALU operand B select: 1 = immediate, 0 = register.
- ImmSrc  out  3  — immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- PCsrc  out  1  — next-PC select: 1 = PC+imm, 0 = PC+4.
- MemWrite  out  1  — data memory write request.
- MemRead  out  1  — data memory read request.
- ResultSrc  out  2  — writeback source: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
- mem_timeout  out  1  — sticky flag; set on data-memory timeout.
- trap  out  1  — core halted in TRAP.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. All strobes default to 0 in every state unless listed below.
- FETCH: wait for instr_valid. On instr_valid: IRWrite=1, then → DECODE.
- DECODE: classify the opcode. Zero outputs.
  - 0010011, 0110011, 0110111, 1100011 or 1101111 → EXEC.
  - 0000011 or 0100011 → MEM; clear the wait counter.
  - Any other opcode → illegal (see Configuration).
- EXEC, one cycle, PCWrite=1, then → FETCH:
  - addi: RegWrite=1, ALUsrc=1, ImmSrc=000, ALUctrl from funct3 (000 add, 110 or, 111 and, 010 slt).
  - R-type: RegWrite=1, ALUsrc=0. funct3=000 with funct7[5]=1 selects sub, otherwise as for addi.
  - lui: RegWrite=1, ImmSrc=100, ResultSrc=11.
  - Branch: ALUctrl=001, ImmSrc=010. PCsrc = (funct3==000 & EQ) | (funct3==001 & !EQ). Other funct3 values: PCsrc=0.
  - jal: RegWrite=1, ImmSrc=011, ResultSrc=10, PCsrc=1.
- MEM: ALUsrc=1, ALUctrl=000, ImmSrc=000 (lw) or 001 (sw). MemRead (lw) or MemWrite (sw) held high until exit.
  - On mem_ready: lw → WB; sw asserts PCWrite=1 in the same cycle, then → FETCH.
  - While !mem_ready: counter increments each cycle.
  - If the counter equals TIMEOUT_MAX and mem_ready=0: set mem_timeout, then take the timeout action (see Configuration).
  - mem_ready wins over timeout in the same cycle.
- WB: RegWrite=1, ResultSrc=01, PCWrite=1, then → FETCH.
- TRAP: trap=1, all strobes 0. Exit only by reset.
- rst_n low, at any state and at any time: state → FETCH, counter → 0, mem_timeout → 0. All outputs are 0 while reset is asserted and in the first FETCH cycle. An in-flight MEM request is dropped immediately.

## Timing
- Outputs are Moore-style from the state register plus combinational decode of `instr`. PCsrc additionally depends on EQ.
- Latency with instr_valid on the first FETCH cycle and mem_ready immediate:
  - ALU, lui, branch, jal: 3 cycles.
  - sw: 3 cycles.
  - lw: 4 cycles.
- Each memory wait cycle adds 1 cycle.
- A timeout exits MEM after exactly TIMEOUT_MAX+1 cycles in MEM.
- FETCH stalls indefinitely while instr_valid=0. No timeout applies to instruction fetch.
- IRWrite lasts exactly one cycle per instruction. PCWrite lasts exactly one cycle per retired instruction.

## Configuration
- TRAP_EN defined:
  - Illegal opcode in DECODE → TRAP.
  - Memory timeout → TRAP; MemRead and MemWrite drop in the cycle after the timeout.
- TRAP_EN undefined:
  - Illegal opcode executes as a NOP: → EXEC with only PCWrite=1.
  - Memory timeout: PCWrite=1 in the timeout cycle, then → FETCH.
  - mem_timeout is still set. trap is tied to 0 and TRAP is unreachable.

## Test plan
- Reset mid-MEM: instr=0x00002183 (lw) → assert rst_n=0 during the wait. Required: outputs 0 immediately, state FETCH, mem_timeout=0 after release.
- addi x1,x0,5: instr=0x00500093, instr_valid=1 → IRWrite in cycle 0; EXEC in cycle 2 with RegWrite=1, ALUsrc=1, ALUctrl=000, PCWrite=1.
- sub: instr=0x40208133 → ALUctrl=001, ALUsrc=0 in EXEC.
- bne: instr=0x00209463 with EQ=0 → PCsrc=1, ImmSrc=010. Same instruction with EQ=1 → PCsrc=0.
- lw with mem_ready after 3 wait cycles: instr=0x00002183 → MemRead high 4 cycles, then WB with ResultSrc=01, RegWrite=1. Total 7 cycles.
- sw, instr=0x00302223, with mem_ready held 0 and TIMEOUT_MAX=15 → mem_timeout set after 16 MEM cycles.
  - TRAP_EN defined: trap=1.
  - TRAP_EN undefined: PCWrite pulse, then FETCH.
- instr=0xFFFFFFFF → TRAP with TRAP_EN defined; without it, one PCWrite pulse and no RegWrite.
